// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the in-order RV32 pipeline.
// Owns the program counter, issues word fetches over a req/ack handshake,
// and feeds {instr, pc, ce} to the decoder through a one-entry skid buffer.
// Redirects that land on an uncancellable in-flight fetch park the FSM in
// DROP until that fetch completes, and its data is then thrown away.
//
// Ports:
//   fs_clk, fs_rst        clock and synchronous active-high reset
//   fs_o_imem_req/addr    fetch request and word address (combinational)
//   fs_i_imem_ack/data    fetch completion and returned instruction
//   fs_i_change_pc/target redirect request and target (low 2 bits ignored)
//   fs_i_stall            decoder cannot accept this cycle
//   fs_i_flush            kill fetched but not yet decoded instructions
//   fs_o_instr/pc/ce      registered instruction, its address, valid
module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                fs_clk,
  input  logic                fs_rst,
  output logic                fs_o_imem_req,
  output logic [PC_WIDTH-1:0] fs_o_imem_addr,
  input  logic                fs_i_imem_ack,
  input  logic [IWIDTH-1:0]   fs_i_imem_data,
  input  logic                fs_i_change_pc,
  input  logic [PC_WIDTH-1:0] fs_i_target_pc,
  input  logic                fs_i_stall,
  input  logic                fs_i_flush,
  output logic [IWIDTH-1:0]   fs_o_instr,
  output logic [PC_WIDTH-1:0] fs_o_pc,
  output logic                fs_o_ce
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [PC_WIDTH-1:0] pc_r, pc_nxt_s;
  logic [PC_WIDTH-1:0] drop_addr_r, drop_addr_nxt_s;
  logic [IWIDTH-1:0]   out_instr_r, out_instr_nxt_s;
  logic [PC_WIDTH-1:0] out_pc_r, out_pc_nxt_s;
  logic                out_ce_r, out_ce_nxt_s;
  logic                skid_valid_r, skid_valid_nxt_s;
  logic [IWIDTH-1:0]   skid_instr_r, skid_instr_nxt_s;
  logic [PC_WIDTH-1:0] skid_pc_r, skid_pc_nxt_s;
  logic                req_s;
  logic [PC_WIDTH-1:0] addr_s;
  logic                accept_s;
  logic                target_lo_unused_s;

  // Redirect targets are word aligned; the low bits are deliberately dropped.
  assign target_lo_unused_s = ^fs_i_target_pc[1:0];

  // Request and address decode from registered state only.
  // FETCH withholds req while the skid is occupied, so the skid can never
  // be asked to hold a second instruction.
  always_comb begin
    req_s  = 1'b0;
    addr_s = pc_r;
    case (state_r)
      ST_IDLE: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
      ST_FETCH: begin
        req_s  = !skid_valid_r;
        addr_s = pc_r;
      end
      ST_DROP: begin
        req_s  = 1'b1;
        addr_s = drop_addr_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
    endcase
  end

  // Only an ack against a live FETCH request delivers a usable instruction.
  assign accept_s = (state_r == ST_FETCH) && req_s && fs_i_imem_ack;

  // Next-state logic: redirect first, then FSM progress and output routing.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    drop_addr_nxt_s  = drop_addr_r;
    out_instr_nxt_s  = out_instr_r;
    out_pc_nxt_s     = out_pc_r;
    out_ce_nxt_s     = out_ce_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_instr_nxt_s = skid_instr_r;
    skid_pc_nxt_s    = skid_pc_r;

    if (fs_i_change_pc) begin
      // Redirect wins over everything; a request still waiting for its ack
      // cannot be withdrawn, so remember its address and wait it out.
      pc_nxt_s         = {fs_i_target_pc[PC_WIDTH-1:2], 2'b00};
      out_ce_nxt_s     = 1'b0;
      skid_valid_nxt_s = 1'b0;
      if (req_s && !fs_i_imem_ack) begin
        state_nxt_s     = ST_DROP;
        drop_addr_nxt_s = addr_s;
      end else begin
        state_nxt_s     = ST_FETCH;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_FETCH;
        end
        ST_FETCH: begin
          if (accept_s) begin
            pc_nxt_s = pc_r + PC_WIDTH'(3'd4);
          end else begin
            pc_nxt_s = pc_r;
          end
        end
        ST_DROP: begin
          if (fs_i_imem_ack) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase

      if (fs_i_flush) begin
        // Kill what is held; the pc still advanced above if a fetch landed.
        out_ce_nxt_s     = 1'b0;
        skid_valid_nxt_s = 1'b0;
      end else if (!fs_i_stall) begin
        if (skid_valid_r) begin
          out_instr_nxt_s  = skid_instr_r;
          out_pc_nxt_s     = skid_pc_r;
          out_ce_nxt_s     = 1'b1;
          skid_valid_nxt_s = 1'b0;
        end else if (accept_s) begin
          out_instr_nxt_s  = fs_i_imem_data;
          out_pc_nxt_s     = pc_r;
          out_ce_nxt_s     = 1'b1;
        end else begin
          out_ce_nxt_s     = 1'b0;
        end
      end else begin
        if (accept_s) begin
          skid_instr_nxt_s = fs_i_imem_data;
          skid_pc_nxt_s    = pc_r;
          skid_valid_nxt_s = 1'b1;
        end else begin
          skid_valid_nxt_s = skid_valid_r;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge fs_clk) begin
    if (fs_rst) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      drop_addr_r  <= RESET_PC;
      out_instr_r  <= {IWIDTH{1'b0}};
      out_pc_r     <= {PC_WIDTH{1'b0}};
      out_ce_r     <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_instr_r <= {IWIDTH{1'b0}};
      skid_pc_r    <= {PC_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      drop_addr_r  <= drop_addr_nxt_s;
      out_instr_r  <= out_instr_nxt_s;
      out_pc_r     <= out_pc_nxt_s;
      out_ce_r     <= out_ce_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_instr_r <= skid_instr_nxt_s;
      skid_pc_r    <= skid_pc_nxt_s;
    end
  end

  assign fs_o_imem_req  = req_s;
  assign fs_o_imem_addr = addr_s;
  assign fs_o_instr     = out_instr_r;
  assign fs_o_pc        = out_pc_r;
  assign fs_o_ce        = out_ce_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run
// checked against a program-order scoreboard and a handshake monitor.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, req, ack, change_pc, stall, flush, ce;
  logic [31:0] addr, data, target, instr, pc;
  logic        stray_ack, mem_rand;
  int          mem_lat, rand_lat, cur_lat, wait_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(RPC)) dut (
    .fs_clk(clk), .fs_rst(rst),
    .fs_o_imem_req(req), .fs_o_imem_addr(addr),
    .fs_i_imem_ack(ack), .fs_i_imem_data(data),
    .fs_i_change_pc(change_pc), .fs_i_target_pc(target),
    .fs_i_stall(stall), .fs_i_flush(flush),
    .fs_o_instr(instr), .fs_o_pc(pc), .fs_o_ce(ce)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA500_0000;
  endfunction

  // Memory model: ack once the request has waited cur_lat cycles.
  assign cur_lat = mem_rand ? rand_lat : mem_lat;
  always_comb begin
    ack  = stray_ack || (req && (wait_cnt >= cur_lat));
    data = mem_word(addr);
  end
  always @(posedge clk) begin
    if (rst || !req || ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (ack) rand_lat <= int'($urandom_range(0, 3));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; change_pc = 1'b0; flush = 1'b0; stall = 1'b0;
    target = 32'h0; stray_ack = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    mem_lat = 0; mem_rand = 1'b0;
    rst = 1'b1; change_pc = 1'b0; flush = 1'b0; stall = 1'b0;
    target = 32'h0; stray_ack = 1'b0;
    tick; tick;
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %0b want 0", ce); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", req); end
    checks++; if (addr !== RPC) begin errors++; $display("FAIL reset_addr got %h want %h", addr, RPC); end
    rst = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL idle_req got %0b want 0", req); end
    tick;
    checks++; if (req !== 1'b1 || addr !== RPC) begin
      errors++; $display("FAIL first_req got req=%0b addr=%h want 1 %h", req, addr, RPC);
    end
  endtask

  task automatic test_streaming;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (ce !== 1'b1 || pc !== 32'(4 * i) || instr !== mem_word(32'(4 * i))) begin
        errors++; $display("FAIL stream got ce=%0b pc=%h instr=%h want pc=%h", ce, pc, instr, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_skid;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset;
    tick; tick; tick;
    checks++; if (pc !== 32'h8 || ce !== 1'b1) begin errors++; $display("FAIL stall_pre got pc=%h want 8", pc); end
    stall = 1'b1; stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (ce !== 1'b1 || pc !== 32'h8 || req !== 1'b0) begin
        errors++; $display("FAIL stall_hold got ce=%0b pc=%h req=%0b want 1 8 0", ce, pc, req);
      end
    end
    stall = 1'b0; stray_ack = 1'b0;
    tick;
    checks++; if (ce !== 1'b1 || pc !== 32'hC || instr !== mem_word(32'hC)) begin
      errors++; $display("FAIL skid_drain got pc=%h instr=%h want c", pc, instr);
    end
    checks++; if (req !== 1'b1 || addr !== 32'h10) begin
      errors++; $display("FAIL skid_rereq got req=%0b addr=%h want 1 10", req, addr);
    end
    tick;
    checks++; if (ce !== 1'b1 || pc !== 32'h10) begin errors++; $display("FAIL post_skid1 got pc=%h want 10", pc); end
    tick;
    checks++; if (ce !== 1'b1 || pc !== 32'h14) begin errors++; $display("FAIL post_skid2 got pc=%h want 14", pc); end
  endtask

  task automatic test_redirect_drop;
    bit seen_new;
    mem_lat = 3; mem_rand = 1'b0;
    do_reset;
    tick;
    change_pc = 1'b1; target = 32'h100;
    tick;
    change_pc = 1'b0;
    seen_new = 1'b0;
    for (int k = 0; k < 12 && !seen_new; k++) begin
      checks++; if (ce !== 1'b0) begin errors++; $display("FAIL drop_ce got %0b pc=%h want 0", ce, pc); end
      if (addr === 32'h100) seen_new = 1'b1;
      else begin
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin
          errors++; $display("FAIL drop_addr got req=%0b addr=%h want 1 0", req, addr);
        end
        tick;
      end
    end
    checks++; if (!seen_new || req !== 1'b1) begin
      errors++; $display("FAIL drop_exit got req=%0b addr=%h want 1 100", req, addr);
    end
    for (int k = 0; k < 12 && ce !== 1'b1; k++) tick;
    checks++; if (ce !== 1'b1 || pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      errors++; $display("FAIL drop_first got ce=%0b pc=%h instr=%h want 1 100", ce, pc, instr);
    end
  endtask

  task automatic test_redirect_ack_stall;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset;
    tick; tick;
    stall = 1'b1; change_pc = 1'b1; target = 32'h203;
    tick;
    change_pc = 1'b0;
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL coinc_ce got %0b want 0", ce); end
    checks++; if (req !== 1'b1 || addr !== 32'h200) begin
      errors++; $display("FAIL coinc_addr got req=%0b addr=%h want 1 200", req, addr);
    end
    stall = 1'b0;
    tick;
    checks++; if (ce !== 1'b1 || pc !== 32'h200) begin errors++; $display("FAIL coinc_next got pc=%h want 200", pc); end
  endtask

  task automatic test_flush_alone;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset;
    tick; tick; tick;
    stall = 1'b1;
    tick;
    checks++; if (req !== 1'b0 || pc !== 32'h8) begin
      errors++; $display("FAIL flush_setup got req=%0b pc=%h want 0 8", req, pc);
    end
    flush = 1'b1;
    tick;
    flush = 1'b0; stall = 1'b0;
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL flush_ce got %0b want 0", ce); end
    checks++; if (req !== 1'b1 || addr !== 32'h10) begin
      errors++; $display("FAIL flush_pc got req=%0b addr=%h want 1 10", req, addr);
    end
    tick;
    checks++; if (ce !== 1'b1 || pc !== 32'h10) begin errors++; $display("FAIL flush_next got pc=%h want 10", pc); end
  endtask

  task automatic test_wrap_reset;
    mem_lat = 0; mem_rand = 1'b0;
    do_reset;
    tick;
    change_pc = 1'b1; target = 32'hFFFF_FFFC;
    tick;
    change_pc = 1'b0;
    checks++; if (ce !== 1'b0 || addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr got ce=%0b addr=%h want 0 fffffffc", ce, addr);
    end
    tick;
    checks++; if (ce !== 1'b1 || pc !== 32'hFFFF_FFFC || instr !== mem_word(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_top got pc=%h instr=%h want fffffffc", pc, instr);
    end
    tick;
    checks++; if (ce !== 1'b1 || pc !== 32'h0 || instr !== mem_word(32'h0)) begin
      errors++; $display("FAIL wrap_zero got pc=%h instr=%h want 0", pc, instr);
    end
    mem_lat = 3;
    tick;
    checks++; if (req !== 1'b1 || addr !== 32'h4) begin
      errors++; $display("FAIL wrap_pending got req=%0b addr=%h want 1 4", req, addr);
    end
    rst = 1'b1; stray_ack = 1'b1;
    tick;
    checks++; if (ce !== 1'b0 || instr !== 32'h0 || pc !== 32'h0 || req !== 1'b0 || addr !== RPC) begin
      errors++; $display("FAIL midreset got ce=%0b instr=%h pc=%h req=%0b addr=%h", ce, instr, pc, req, addr);
    end
    tick;
    rst = 1'b0; mem_lat = 0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL midreset_idle got req=%0b want 0", req); end
    tick;
    stray_ack = 1'b0;
    checks++; if (req !== 1'b1 || addr !== RPC || ce !== 1'b0) begin
      errors++; $display("FAIL restart got req=%0b addr=%h ce=%0b want 1 %h 0", req, addr, ce, RPC);
    end
    tick;
    checks++; if (ce !== 1'b1 || pc !== RPC || instr !== mem_word(RPC)) begin
      errors++; $display("FAIL restart_out got pc=%h instr=%h want %h", pc, instr, RPC);
    end
  endtask

  // Random stalls, latencies, stray acks and redirects. The decoder consumes
  // an instruction on any edge where ce=1 with no stall and no redirect;
  // consumed addresses must follow program order from the last redirect.
  task automatic test_random;
    logic [31:0] exp_pc, ntgt, p_addr;
    logic        p_req, p_ack, nstall, nchg;
    int          consumed;
    mem_lat = 0; mem_rand = 1'b1;
    do_reset;
    exp_pc = RPC; consumed = 0;
    p_req = req; p_ack = ack; p_addr = addr;
    for (int c = 0; c < 2000; c++) begin
      tick;
      if (p_req && !p_ack) begin
        checks++; if (req !== 1'b1 || addr !== p_addr) begin
          errors++; $display("FAIL rand_hold got req=%0b addr=%h want 1 %h", req, addr, p_addr);
        end
      end
      nstall = ($urandom_range(0, 9) < 3);
      nchg   = ($urandom_range(0, 19) == 0);
      ntgt   = 32'($urandom_range(0, 4095));
      if (ce && !nstall && !nchg) begin
        checks++; if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rand_order got pc=%h instr=%h want pc=%h", pc, instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (nchg) exp_pc = ntgt & 32'hFFFF_FFFC;
      stall = nstall; change_pc = nchg; flush = nchg; target = ntgt;
      stray_ack = ($urandom_range(0, 15) == 0);
      #1;
      p_req = req; p_ack = ack; p_addr = addr;
    end
    checks++; if (consumed < 200) begin
      errors++; $display("FAIL rand_throughput got %0d want >= 200", consumed);
    end
    stall = 1'b0; change_pc = 1'b0; flush = 1'b0; stray_ack = 1'b0; mem_rand = 1'b0;
  endtask

  initial begin
    rst = 1'b1; change_pc = 1'b0; flush = 1'b0; stall = 1'b0;
    target = 32'h0; stray_ack = 1'b0; mem_rand = 1'b0; mem_lat = 0;
    test_reset;
    test_streaming;
    test_stall_skid;
    test_redirect_drop;
    test_redirect_ack_stall;
    test_flush_alone;
    test_wrap_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
